muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle multiply/divide unit with HI/LO registers. Sits beside the EX-stage ALU and
//   executes mult/multu/div/divu via an iterative shift-add / restoring-divide datapath
//   sequenced by an internal FSM. busy drives the hazard unit, which stalls mfhi/mflo/mthi/mtlo
//   and new muldiv ops. The single-cycle ALU mul path is unaffected.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are WIDTH bits each
// PORTS
//   clk       in   1      clock, all state updates on rising edge
//   reset_n   in   1      synchronous reset, active low
//   start     in   1      launch an operation; sampled only in IDLE
//   op        in   2      00 mult, 01 multu, 10 div, 11 divu
//   rs_data   in   WIDTH  multiplicand / dividend
//   rt_data   in   WIDTH  multiplier / divisor
//   cancel    in   1      abort in-flight op (pipeline flush)
//   hi_we     in   1      mthi write enable
//   lo_we     in   1      mtlo write enable
//   wdata     in   WIDTH  mthi/mtlo data
//   busy      out  1      operation in flight; hazard unit stalls on it
//   done      out  1      one-cycle pulse; HI/LO hold the new result
//   hi        out  WIDTH  HI register (product high half / remainder)
//   lo        out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//   - Reset (reset_n=0 at edge): state=IDLE, busy=0, done=0, hi=0, lo=0, internal regs cleared.
//     Reset overrides every other input, including mid-operation.
//   - FSM: IDLE -> CALC on start. CALC runs exactly WIDTH iterations (counter WIDTH-1..0).
//     CALC -> SIGN when counter reaches 0. SIGN -> DONE always. DONE -> IDLE always.
//   - Timing: start sampled at edge k. busy=1 during cycles k+1..k+WIDTH+1 (CALC + SIGN).
//     At edge k+WIDTH+2, hi/lo are written and the FSM enters DONE.
//     done=1 and busy=0 for that single cycle. Start-to-done latency: WIDTH+2 cycles.
//   - In DONE a new start is NOT accepted. It is accepted in the following IDLE cycle.
//     start in CALC/SIGN/DONE is ignored.
//   - Operands are latched at the accepting edge. rs_data/rt_data may change afterwards.
//   - Signed ops (op[0]=0): magnitudes are taken in IDLE and iterated unsigned.
//     SIGN negates the product if operand signs differ.
//     div: quotient negated if signs differ; remainder takes the dividend's sign.
//   - Products are full 2*WIDTH: hi = [2W-1:W], lo = [W-1:0]. No overflow flag.
//   - Divide by zero (rt_data=0, any div op): same latency, no exception.
//     lo = all ones, hi = rs_data (original, unsigned view).
//   - Signed overflow, div with rs=-2^(W-1) and rt=-1: lo = 0x80000000, hi = 0.
//   - hi_we/lo_we: applied at the edge only when the state is IDLE or DONE. Ignored while busy.
//     If a write coincides with an accepted start, the write lands and the later result
//     overwrites it.
//   - cancel=1 in CALC/SIGN: FSM -> IDLE at next edge, hi/lo unchanged, no done.
//     cancel in IDLE/DONE has no effect. If cancel and start are both 1 in IDLE, start is
//     NOT accepted.
//   - Outputs are registered. done is a pure decode of state==DONE. busy = CALC|SIGN.
// TESTING
//   - multu 0xFFFFFFFF*0xFFFFFFFF -> done at cycle k+34, hi=0xFFFFFFFE, lo=0x00000001, busy 33 cycles
//   - mult -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
//   - divu 100/0 -> lo=0xFFFFFFFF, hi=100. div 0x80000000/-1 -> lo=0x80000000, hi=0
//   - start pulsed again at cycles k+5 and k+33 during an op -> ignored; single done; hi/lo = first result
//   - cancel at k+10 -> busy low at k+11, no done, hi/lo keep prior values. reset_n=0 at k+20 of
//     a new op -> hi=lo=0, IDLE
//   - mthi 0x1234 while busy -> ignored. mtlo 0x55 in IDLE -> lo=0x55 next cycle

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Bundles the operation request, HI/LO write port and status/result signals of
//   the multi-cycle multiply/divide unit.
//   master : issuing side (EX stage / hazard unit), drives start/op/operands/cancel/writes
//   slave  : the muldiv_sequencer, drives busy/done/hi/lo
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, cancel, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, cancel, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit with HI/LO registers. mult/multu use a shift-add
//   datapath, div/divu a restoring divider; both run on operand magnitudes and the
//   SIGN state applies the result signs. One op takes WIDTH+1 busy cycles, then a
//   single done cycle.
// Ports
//   clk      : clock, rising edge
//   reset_n  : synchronous reset, active low
//   bus      : slave side of muldiv_sequencer_if
//              in : start, op (00 mult, 01 multu, 10 div, 11 divu), rs_data, rt_data,
//                   cancel, hi_we, lo_we, wdata
//              out: busy, done, hi, lo
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting; accepts start (unless cancel), mthi/mtlo writes land
// CALC   | WIDTH iterations, counter WIDTH-1 down to 0; cancel aborts
// SIGN   | applies result signs / special cases, writes HI/LO; cancel aborts
// DONE   | one-cycle done pulse; mthi/mtlo writes land, start ignored
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  // mult: {partial product high, multiplier shifting out}
  // div : {partial remainder, dividend shifting into quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   rs_raw;    // original dividend, returned as HI on divide by zero
  logic               is_div;
  logic               neg_main;  // negate product / quotient
  logic               neg_rem;   // negate remainder
  logic               div_zero;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_op;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl_rem;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    signed_op = ~bus.op[0];
    rs_mag    = (signed_op && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    rt_mag    = (signed_op && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
  end

  // One iteration of either datapath. For the divider the shifted remainder can
  // need WIDTH+1 bits, but whenever it does the subtraction succeeds, so the
  // kept remainder always fits WIDTH bits.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shl_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = shl_rem - {1'b0, opnd};
    acc_next = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!trial[WIDTH]) acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_next = {shl_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_main ? -acc : acc;
    quo_fix  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      rs_raw   <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start && !bus.cancel) begin
            state    <= S_CALC;
            busy_q   <= 1'b1;
            cnt      <= CW'(WIDTH - 1);
            is_div   <= bus.op[1];
            neg_main <= signed_op & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
            neg_rem  <= signed_op & bus.rs_data[WIDTH-1];
            div_zero <= bus.op[1] & (bus.rt_data == '0);
            rs_raw   <= bus.rs_data;
            opnd     <= bus.op[1] ? rt_mag : rs_mag;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
          end
        end
        S_CALC: begin
          if (bus.cancel) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            acc <= acc_next;
            if (cnt == '0) state <= S_SIGN;
            else           cnt   <= cnt - 1'b1;
          end
        end
        S_SIGN: begin
          state  <= bus.cancel ? S_IDLE : S_DONE;
          busy_q <= 1'b0;
          if (!bus.cancel) begin
            done_q <= 1'b1;
            if (!is_div) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi_q <= rs_raw;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        S_DONE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  muldiv_sequencer_if #(.WIDTH(32)) mif ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    mif.op      = o;
    mif.rs_data = a;
    mif.rt_data = b;
    mif.start   = 1'b1;
    step();
    mif.start   = 1'b0;
    mif.rs_data = $urandom;
    mif.rt_data = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!mif.done && n < 60) begin
      step();
      n++;
    end
    check({tag, " done seen"}, 64'(mif.done), 64'd1);
  endtask

  // Full op with latency/busy-length checks; edges counted include the accepting edge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int edges;
    int busy_n;
    issue(o, a, b);
    edges  = 1;
    busy_n = mif.busy ? 1 : 0;
    while (!mif.done && edges < 60) begin
      step();
      edges++;
      if (mif.busy) busy_n++;
    end
    check({tag, " latency"}, 64'(edges), 64'd34);
    check({tag, " busy cycles"}, 64'(busy_n), 64'd33);
    check({tag, " hi"}, 64'(mif.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(mif.lo), 64'(exp_lo));
    step();
    check({tag, " done pulse"}, 64'(mif.done), 64'd0);
  endtask

  initial begin
    int n_done;
    int done_edge;
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    mif.start     = 1'b0;
    mif.op        = 2'b00;
    mif.rs_data   = '0;
    mif.rt_data   = '0;
    mif.cancel    = 1'b0;
    mif.hi_we     = 1'b0;
    mif.lo_we     = 1'b0;
    mif.wdata     = '0;
    step();
    step();
    reset_n = 1'b1;
    check("reset busy", 64'(mif.busy), 64'd0);
    check("reset done", 64'(mif.done), 64'd0);
    check("reset hi", 64'(mif.hi), 64'd0);
    check("reset lo", 64'(mif.lo), 64'd0);

    // mtlo in IDLE
    mif.lo_we = 1'b1;
    mif.wdata = 32'h55;
    step();
    mif.lo_we = 1'b0;
    check("mtlo idle", 64'(mif.lo), 64'h55);

    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -7*3", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 100/0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu 1000/7", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142);

    // start re-pulsed during an op (before edges 5 and 33) is ignored
    issue(2'b01, 32'd6, 32'd7);
    n_done    = 0;
    done_edge = 0;
    for (int e = 2; e <= 45; e++) begin
      mif.start   = (e == 5 || e == 33);
      mif.op      = 2'b00;
      mif.rs_data = 32'd1;
      mif.rt_data = 32'd1;
      step();
      if (mif.done) begin
        n_done++;
        done_edge = e;
      end
    end
    mif.start = 1'b0;
    check("repulse done count", 64'(n_done), 64'd1);
    check("repulse done edge", 64'(done_edge), 64'd34);
    check("repulse hi", 64'(mif.hi), 64'd0);
    check("repulse lo", 64'(mif.lo), 64'd42);
    check("repulse idle", 64'(mif.busy), 64'd0);

    // mthi while busy is ignored
    issue(2'b01, 32'd2, 32'd3);
    step();
    step();
    mif.hi_we = 1'b1;
    mif.wdata = 32'h1234;
    step();
    mif.hi_we = 1'b0;
    check("mthi busy ignored", 64'(mif.hi), 64'd0);
    wait_done("mthi busy");
    check("mthi busy hi", 64'(mif.hi), 64'd0);
    check("mthi busy lo", 64'(mif.lo), 64'd6);
    step();

    // cancel at edge 10 of an op
    issue(2'b01, 32'd5, 32'd5);
    for (int i = 0; i < 9; i++) step();
    check("cancel pre busy", 64'(mif.busy), 64'd1);
    mif.cancel = 1'b1;
    step();
    mif.cancel = 1'b0;
    check("cancel busy", 64'(mif.busy), 64'd0);
    check("cancel done", 64'(mif.done), 64'd0);
    check("cancel hi", 64'(mif.hi), 64'd0);
    check("cancel lo", 64'(mif.lo), 64'd6);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mif.done) n_done++;
    end
    check("cancel no done", 64'(n_done), 64'd0);

    // cancel together with start in IDLE blocks acceptance
    mif.cancel = 1'b1;
    issue(2'b01, 32'd9, 32'd9);
    mif.cancel = 1'b0;
    check("cancel+start", 64'(mif.busy), 64'd0);

    // mtlo coinciding with accepted start lands, then result overwrites it
    mif.lo_we = 1'b1;
    mif.wdata = 32'hAAAA;
    issue(2'b01, 32'd3, 32'd3);
    mif.lo_we = 1'b0;
    check("wr+start lo", 64'(mif.lo), 64'hAAAA);
    check("wr+start busy", 64'(mif.busy), 64'd1);
    wait_done("wr+start");
    check("wr+start result", 64'(mif.lo), 64'd9);
    // in DONE: mtlo lands, start ignored
    mif.lo_we = 1'b1;
    mif.wdata = 32'h77;
    mif.start = 1'b1;
    step();
    mif.lo_we = 1'b0;
    mif.start = 1'b0;
    check("mtlo in done", 64'(mif.lo), 64'h77);
    check("start in done", 64'(mif.busy), 64'd0);
    step();
    check("after done start", 64'(mif.busy), 64'd0);

    // reset mid-operation
    mif.hi_we = 1'b1;
    mif.wdata = 32'hDEAD;
    step();
    mif.hi_we = 1'b0;
    check("mthi idle", 64'(mif.hi), 64'hDEAD);
    issue(2'b11, 32'd1000, 32'd7);
    for (int i = 0; i < 19; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midreset hi", 64'(mif.hi), 64'd0);
    check("midreset lo", 64'(mif.lo), 64'd0);
    check("midreset busy", 64'(mif.busy), 64'd0);
    check("midreset done", 64'(mif.done), 64'd0);
    run_op("post reset multu", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
